// File: rtl/bsg_link_isdr_rx_pkg.sv
// Shared constants and types for the ISDR receive buffer.
package bsg_link_isdr_rx_pkg;

  localparam int RX_CNT_W = 32;

  // Width of a captured PHY word: payload plus its valid bit.
  function automatic int phy_word_w(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/bsg_link_isdr_rx_buffer_if.sv
// PHY-side and core-side signals of the ISDR receive buffer.
interface bsg_link_isdr_rx_buffer_if #(parameter int width_p = 8);
  import bsg_link_isdr_rx_pkg::*;

  logic                io_valid_i;
  logic [width_p-1:0]  io_data_i;
  logic                core_valid_o;
  logic [width_p-1:0]  core_data_o;
  logic                core_yumi_i;
  logic                token_o;
  logic                overflow_o;
  logic [RX_CNT_W-1:0] rx_count_o;

  modport slave (
    input  io_valid_i, io_data_i, core_yumi_i,
    output core_valid_o, core_data_o, token_o, overflow_o, rx_count_o
  );

  modport master (
    output io_valid_i, io_data_i, core_yumi_i,
    input  core_valid_o, core_data_o, token_o, overflow_o, rx_count_o
  );
endinterface

// File: rtl/bsg_link_isdr_token_gen.sv
// Credit decimation counter: toggles token_o once per 2^lg_credit_decimation_p credits.
module bsg_link_isdr_token_gen #(
  parameter int lg_credit_decimation_p = 2
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic credit_v_i,
  output logic token_o
);

  logic w_wrap;

  if (lg_credit_decimation_p == 0) begin : g_nodec
    assign w_wrap = credit_v_i;
  end else begin : g_dec
    logic [lg_credit_decimation_p-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)      r_cnt <= '0;
      else if (credit_v_i) r_cnt <= r_cnt + lg_credit_decimation_p'(1);
    end

    assign w_wrap = credit_v_i & (&r_cnt);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  token_o <= 1'b0;
    else if (w_wrap) token_o <= ~token_o;
  end

endmodule

// File: rtl/bsg_link_isdr_rx_buffer.sv
// Receive FIFO behind the input SDR PHY with decimated credit-token return.
// Optional macro BSG_LINK_ISDR_RX_COUNT_EN enables the received-word counter.
module bsg_link_isdr_rx_buffer
  import bsg_link_isdr_rx_pkg::*;
#(
  parameter int width_p                = 8,
  parameter int lg_fifo_depth_p        = 3,
  parameter int lg_credit_decimation_p = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  bsg_link_isdr_rx_buffer_if.slave    bus
);

  localparam int DEPTH = 1 << lg_fifo_depth_p;
  localparam int PW    = lg_fifo_depth_p + 1;

  typedef struct packed {
    logic               v;
    logic [width_p-1:0] data;
  } phy_word_t;

  phy_word_t          w_in;
  logic [PW-1:0]      r_wptr, r_rptr;
  logic [width_p-1:0] r_mem [DEPTH];
  logic               w_empty, w_full, w_deq, w_enq;
  logic               r_overflow;

  assign w_in    = '{v: bus.io_valid_i, data: bus.io_data_i};
  assign w_empty = (r_wptr == r_rptr);
  // Full when the pointers differ only in the wrap bit.
  assign w_full  = ((r_wptr ^ r_rptr) == PW'(DEPTH));
  assign w_deq   = bus.core_yumi_i & ~w_empty;
  assign w_enq   = w_in.v & (~w_full | w_deq);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + PW'(1);
      if (w_deq) r_rptr <= r_rptr + PW'(1);
      if (w_in.v & w_full & ~w_deq) r_overflow <= 1'b1;
    end
  end

  // Storage is deliberately not reset; the pointers alone define contents.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr[lg_fifo_depth_p-1:0]] <= w_in.data;
  end

  assign bus.core_valid_o = ~w_empty;
  assign bus.core_data_o  = r_mem[r_rptr[lg_fifo_depth_p-1:0]];
  assign bus.overflow_o   = r_overflow;

  bsg_link_isdr_token_gen #(
    .lg_credit_decimation_p(lg_credit_decimation_p)
  ) u_token_gen (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .credit_v_i (w_deq),
    .token_o    (bus.token_o)
  );

`ifdef BSG_LINK_ISDR_RX_COUNT_EN
  logic [RX_CNT_W-1:0] r_rx_cnt;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_rx_cnt <= '0;
    else if (w_enq) r_rx_cnt <= r_rx_cnt + RX_CNT_W'(1);
  end

  assign bus.rx_count_o = r_rx_cnt;
`else
  assign bus.rx_count_o = '0;
`endif

endmodule

// File: tb/tb_bsg_link_isdr_rx_buffer.sv
// Directed plus randomized bench for bsg_link_isdr_rx_buffer against a queue model.
module tb_bsg_link_isdr_rx_buffer;
  localparam int W     = 8;
  localparam int DEPTH = 8;
  localparam int LGC   = 2;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  bsg_link_isdr_rx_buffer_if #(.width_p(W)) bus();

  bsg_link_isdr_rx_buffer #(
    .width_p(W), .lg_fifo_depth_p(3), .lg_credit_decimation_p(LGC)
  ) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (bus)
  );

  // Reference model: contents as a queue, counts of events.
  logic [W-1:0] q[$];
  int  ndeq = 0;
  int  rxcnt = 0;
  bit  ovf = 0;
  int  errs = 0;
  int  checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rx();
`ifdef BSG_LINK_ISDR_RX_COUNT_EN
    return rxcnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_outs(input string ph);
    chk({ph, ".valid"}, {31'd0, bus.core_valid_o}, {31'd0, q.size() != 0});
    if (q.size() != 0) chk({ph, ".data"}, {24'd0, bus.core_data_o}, {24'd0, q[0]});
    chk({ph, ".token"}, {31'd0, bus.token_o}, ((ndeq >> LGC) & 1));
    chk({ph, ".overflow"}, {31'd0, bus.overflow_o}, {31'd0, ovf});
    chk({ph, ".rx_count"}, bus.rx_count_o, exp_rx());
  endtask

  // Called at a negedge: drive, verify no input-to-output path, clock, verify.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic y);
    bit deq, full;
    bus.io_valid_i = v; bus.io_data_i = d; bus.core_yumi_i = y;
    #1 check_outs("pre");
    @(posedge clk_i);
    deq  = y && (q.size() > 0);
    full = (q.size() == DEPTH);
    if (deq) begin void'(q.pop_front()); ndeq++; end
    if (v) begin
      if (!full || deq) begin q.push_back(d); rxcnt++; end
      else ovf = 1;
    end
    @(negedge clk_i);
    check_outs("post");
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    bus.io_valid_i = 1'b0; bus.io_data_i = '0; bus.core_yumi_i = 1'b0;
    q.delete(); ndeq = 0; rxcnt = 0; ovf = 0;
    repeat (2) @(negedge clk_i);
    check_outs("reset");
    reset_n_i = 1'b1;
  endtask

  initial begin
    bus.io_valid_i = 1'b0; bus.io_data_i = '0; bus.core_yumi_i = 1'b0;
    @(negedge clk_i);
    do_reset();

    // Single word latency.
    cyc(1'b1, 8'hA5, 1'b0);
    chk("a5.valid", {31'd0, bus.core_valid_o}, 32'd1);
    chk("a5.data", {24'd0, bus.core_data_o}, 32'hA5);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);  // illegal yumi while empty

    // Fill, overflow, drain.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(i), 1'b0);
    cyc(1'b1, 8'h99, 1'b0);
    chk("ovf.set", {31'd0, bus.overflow_o}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("drain.order", {24'd0, bus.core_data_o}, i);
      cyc(1'b0, 8'h00, 1'b1);
    end
    chk("drain.empty", {31'd0, bus.core_valid_o}, 32'd0);

    // Full with simultaneous enqueue/dequeue.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
    cyc(1'b1, 8'h5A, 1'b1);
    chk("simul.noovf", {31'd0, bus.overflow_o}, 32'd0);
    chk("simul.occ", q.size(), 32'd8);
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("simul.empty", {31'd0, bus.core_valid_o}, 32'd0);

    // Twelve dequeues toggle the token three times.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 12; i++) cyc(i < 4, 8'($urandom), 1'b1);
    chk("token.end", {31'd0, bus.token_o}, 32'd1);

    // Received-word count: 10 accepted, 1 dropped.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(i), 1'b0);
    cyc(1'b1, 8'hEE, 1'b0);
    cyc(1'b1, 8'h08, 1'b1);
    cyc(1'b1, 8'h09, 1'b1);
`ifdef BSG_LINK_ISDR_RX_COUNT_EN
    chk("rxcount.10", bus.rx_count_o, 32'd10);
`else
    chk("rxcount.off", bus.rx_count_o, 32'd0);
`endif

    // Randomized traffic with occasional illegal yumi.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic v, y;
      v = ($urandom_range(0, 99) < 55);
      y = (q.size() > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 9) == 0);
      cyc(v, 8'($urandom), y);
    end

    // Asynchronous reset mid-cycle with 5 entries and token high.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
    chk("arst.pre_token", {31'd0, bus.token_o}, 32'd1);
    chk("arst.pre_occ", q.size(), 32'd5);
    #2 reset_n_i = 1'b0;
    #1;
    chk("arst.valid", {31'd0, bus.core_valid_o}, 32'd0);
    chk("arst.token", {31'd0, bus.token_o}, 32'd0);
    chk("arst.overflow", {31'd0, bus.overflow_o}, 32'd0);
    chk("arst.rx_count", bus.rx_count_o, 32'd0);
    q.delete(); ndeq = 0; rxcnt = 0; ovf = 0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h3C, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
